tdm_demux4: RTL and testbench

- Receiving end of the 4-to-1 channel multiplexing path.
- A transmitter time-division-multiplexes four channels onto one stream, one slot per beat, slot 0 marked by frame_sync.
- This block locks onto the frame, steers each slot into its channel's shadow register and presents all four channels in parallel once per frame, with a one-cycle valid pulse.
- Sits between the serial link and the per-channel consumers.

---
 rtl/tdm_pkg.sv | 6 +
 rtl/tdm_slot_ctr.sv | 24 ++
 rtl/tdm_demux4.sv | 100 ++++++++++
 tb/tb_tdm_demux4.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: slot geometry and framing states shared by the TDM transmitter and receiver.
package tdm_pkg;
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
    typedef enum logic {HUNT, LOCK} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot index with clear, load-to-1 and wrapping increment.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);
    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = clr ? '0 : load1 ? SLOT_W'(1) : inc ? slot_q + SLOT_W'(1) : slot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign slot = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: locks onto frame_sync, steers TDM slots into shadow registers and
// presents all four channels in parallel once per complete frame.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [WIDTH-1:0]  out0,
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    output logic [WIDTH-1:0]  out3,
    output logic              out_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);
    state_t                              state_q, state_d;
    logic [WIDTH-1:0]                    shadow_q [NUM_SLOTS-1];
    logic [WIDTH-1:0]                    shadow_d [NUM_SLOTS-1];
    logic [NUM_SLOTS-1:0][WIDTH-1:0]     out_q, out_d;
    logic                                out_valid_q, out_valid_d;
    logic                                sync_err_q, sync_err_d;
    logic                                clr, load1, inc;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .load1 (load1),
        .inc   (inc),
        .slot  (slot)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        clr         = 1'b0;
        load1       = 1'b0;
        inc         = 1'b0;
        if (din_valid) begin
            if (state_q == HUNT) begin
                if (frame_sync) begin
                    shadow_d[0] = din;
                    load1       = 1'b1;
                    state_d     = LOCK;
                end
            end else if (frame_sync) begin
                // A sync at slot 0 is the normal frame start; anywhere else it
                // drops the partial frame and restarts from this beat.
                shadow_d[0] = din;
                load1       = 1'b1;
                sync_err_d  = (slot != '0);
            end else if (slot == '0) begin
                sync_err_d = 1'b1;
                clr        = 1'b1;
                state_d    = HUNT;
            end else begin
                inc = 1'b1;
                for (int i = 1; i < NUM_SLOTS - 1; i++)
                    if (slot == SLOT_W'(i)) shadow_d[i] = din;
                if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
                    out_d       = {din, shadow_q[2], shadow_q[1], shadow_q[0]};
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            shadow_q    <= '{default: '0};
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign locked    = (state_q == LOCK);
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed-vector bench for tdm_demux4 with WIDTH=4.
module tb_tdm_demux4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [3:0] out0, out1, out2, out3;
    logic       out_valid, locked, sync_err;
    logic [1:0] slot;
    int         total = 0;
    int         passed = 0;

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out_valid  (out_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input logic [15:0] outs, input logic ov,
                             input logic [1:0] sl, input logic lk, input logic se);
        chk({tag, ".outs"}, {16'h0, out3, out2, out1, out0}, {16'h0, outs});
        chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, ov});
        chk({tag, ".slot"}, {30'h0, slot}, {30'h0, sl});
        chk({tag, ".locked"}, {31'h0, locked}, {31'h0, lk});
        chk({tag, ".sync_err"}, {31'h0, sync_err}, {31'h0, se});
    endtask

    task automatic beat(input logic [3:0] d, input logic fs);
        din        = d;
        frame_sync = fs;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        din        = 4'h0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        #1;
        idle();
        chk_state("reset_held", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        idle();
        chk_state("reset_released", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);

        beat(4'hA, 1'b1);
        chk_state("clean_a", 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0);
        beat(4'hB, 1'b0);
        beat(4'hC, 1'b0);
        chk_state("clean_c", 16'h0000, 1'b0, 2'd3, 1'b1, 1'b0);
        beat(4'hD, 1'b0);
        chk_state("clean_done", 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0);
        idle();
        chk_state("clean_pulse_end", 16'hDCBA, 1'b0, 2'd0, 1'b1, 1'b0);

        do_reset();
        beat(4'h5, 1'b0);
        beat(4'h6, 1'b0);
        chk_state("hunt_discard", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        chk_state("hunt_frame", 16'h4321, 1'b1, 2'd0, 1'b1, 1'b0);

        beat(4'h7, 1'b1);
        beat(4'h8, 1'b0);
        idle();
        idle();
        chk_state("gap_idle", 16'h4321, 1'b0, 2'd2, 1'b1, 1'b0);
        beat(4'h9, 1'b0);
        chk_state("gap_slot2", 16'h4321, 1'b0, 2'd3, 1'b1, 1'b0);
        beat(4'hE, 1'b0);
        chk_state("gap_done", 16'hE987, 1'b1, 2'd0, 1'b1, 1'b0);

        beat(4'h1, 1'b1);
        beat(4'h2, 1'b0);
        beat(4'h9, 1'b1);
        chk_state("early_sync", 16'hE987, 1'b0, 2'd1, 1'b1, 1'b1);
        beat(4'h8, 1'b0);
        chk_state("early_pulse_end", 16'hE987, 1'b0, 2'd2, 1'b1, 1'b0);
        beat(4'h7, 1'b0);
        beat(4'h6, 1'b0);
        chk_state("early_done", 16'h6789, 1'b1, 2'd0, 1'b1, 1'b0);

        beat(4'h3, 1'b0);
        chk_state("miss_sync", 16'h6789, 1'b0, 2'd0, 1'b0, 1'b1);
        beat(4'h4, 1'b0);
        chk_state("miss_hunt", 16'h6789, 1'b0, 2'd0, 1'b0, 1'b0);
        beat(4'h1, 1'b1);
        chk_state("relock", 16'h6789, 1'b0, 2'd1, 1'b1, 1'b0);
        beat(4'h2, 1'b0);
        beat(4'h3, 1'b0);
        beat(4'h4, 1'b0);
        chk_state("relock_done", 16'h4321, 1'b1, 2'd0, 1'b1, 1'b0);

        beat(4'h5, 1'b1);
        beat(4'h6, 1'b0);
        beat(4'h7, 1'b0);
        chk_state("pre_reset", 16'h4321, 1'b0, 2'd3, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_state("async_reset", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b1;
        beat(4'h8, 1'b0);
        chk_state("post_reset_beat", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        beat(4'hA, 1'b1);
        beat(4'hB, 1'b0);
        beat(4'hC, 1'b0);
        chk_state("post_reset_partial", 16'h0000, 1'b0, 2'd3, 1'b1, 1'b0);
        beat(4'hD, 1'b0);
        chk_state("post_reset_done", 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
